// File: rtl/fmul_pkg.sv
// Shared types and defaults for the fraction-multiplier sharing controller.
// Pulled in by both the top-level controller and the round-robin arbiter.
package fmul_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEF_OP_W    = 4;
    localparam int DEF_PROD_W  = 7;
    localparam int DEF_TIMEOUT = 32;

    // Index one past idx, wrapping back to 0 at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a stored pointer.
// The pointer moves one past the winner whenever advance is pulsed.
module rr_arbiter
    import fmul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // Scan upward from the pointer with wrap; the first asserted request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            ptr <= IDX_W'(wrap_inc(int'(grant_idx), N_REQ));
        end
    end

endmodule

// File: rtl/fmul_share_ctrl.sv
// Shares one fraction_multiplication unit among N_REQ requesters, one operation
// in flight at a time, returning the product or a timeout error to the owner.
module fmul_share_ctrl
    import fmul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int OP_W    = DEF_OP_W,
    parameter int PROD_W  = DEF_PROD_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*OP_W-1:0] req_mplier,
    input  logic [N_REQ*OP_W-1:0] req_mcand,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [PROD_W-1:0]     rsp_product,
    output logic                  rsp_error,
    output logic                  busy,
    output logic                  mul_st,
    output logic [OP_W-1:0]       mul_mplier,
    output logic [OP_W-1:0]       mul_mcand,
    input  logic [PROD_W-1:0]     mul_product,
    input  logic                  mul_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [TMR_W-1:0]   timer;
    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               transfer;
    logic [OP_W-1:0]    sel_mplier;
    logic [OP_W-1:0]    sel_mcand;
    logic [N_REQ-1:0]   owner_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign transfer     = (state == IDLE) && grant_any;
    assign req_ready    = (state == IDLE) ? grant : '0;
    assign owner_onehot = N_REQ'(1) << owner;

    always_comb begin
        sel_mplier = '0;
        sel_mcand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_mplier = req_mplier[i*OP_W +: OP_W];
                sel_mcand  = req_mcand[i*OP_W +: OP_W];
            end
        end
    end

    // The first WAIT cycle (timer == 0) ignores Done, which may still be high
    // from the previous operation; a real Done beats a simultaneous timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            mul_st      <= 1'b0;
            mul_mplier  <= '0;
            mul_mcand   <= '0;
            rsp_valid   <= '0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        owner      <= grant_idx;
                        mul_mplier <= sel_mplier;
                        mul_mcand  <= sel_mcand;
                        mul_st     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    mul_st <= 1'b0;
                    timer  <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (timer != '0 && mul_done) begin
                        rsp_valid   <= owner_onehot;
                        rsp_product <= mul_product;
                        rsp_error   <= 1'b0;
                        mul_mplier  <= '0;
                        mul_mcand   <= '0;
                        state       <= RESP;
                    end else if (timer == TMR_LAST) begin
                        rsp_valid   <= owner_onehot;
                        rsp_product <= '0;
                        rsp_error   <= 1'b1;
                        mul_mplier  <= '0;
                        mul_mcand   <= '0;
                        state       <= RESP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid   <= '0;
                    rsp_product <= '0;
                    rsp_error   <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Directed-plus-random bench for fmul_share_ctrl with a stub multiplier whose
// Done latency is programmable; expectations come from a round-robin model.
module tb_fmul_share_ctrl;

    localparam int N  = 4;
    localparam int OW = 4;
    localparam int PW = 7;
    localparam int TO = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*OW-1:0] req_mplier;
    logic [N*OW-1:0] req_mcand;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [PW-1:0]   rsp_product;
    logic            rsp_error;
    logic            busy;
    logic            mul_st;
    logic [OW-1:0]   mul_mplier;
    logic [OW-1:0]   mul_mcand;
    logic [PW-1:0]   mul_product;
    logic            mul_done;

    logic [OW-1:0]   a_op [N];
    logic [OW-1:0]   b_op [N];
    int              stub_lat;
    int              stub_cnt;
    logic            stub_active;
    logic            stub_done;
    logic            stale_done;
    int              ptr_m;
    int              check_cnt;
    int              pass_cnt;

    fmul_share_ctrl #(
        .N_REQ   (N),
        .OP_W    (OW),
        .PROD_W  (PW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_mplier  (req_mplier),
        .req_mcand   (req_mcand),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_error   (rsp_error),
        .busy        (busy),
        .mul_st      (mul_st),
        .mul_mplier  (mul_mplier),
        .mul_mcand   (mul_mcand),
        .mul_product (mul_product),
        .mul_done    (mul_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_mplier = '0;
        req_mcand  = '0;
        for (int i = 0; i < N; i++) begin
            req_mplier[i*OW +: OW] = a_op[i];
            req_mcand[i*OW +: OW]  = b_op[i];
        end
    end

    // Stub multiplier: Done pulses stub_lat cycles after it samples St; 0 means never.
    assign mul_product = PW'(int'(mul_mplier) * int'(mul_mcand));
    assign mul_done    = stub_done | stale_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_active <= 1'b0;
            stub_cnt    <= 0;
            stub_done   <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (mul_st) begin
                stub_active <= (stub_lat != 0);
                stub_cnt    <= stub_lat;
            end else if (stub_active) begin
                if (stub_cnt == 1) begin
                    stub_done   <= 1'b1;
                    stub_active <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Round-robin reference: first requester at/after the model pointer, with wrap.
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr_m + k) % N;
            if (v[c] === 1'b1) return c;
        end
        return 0;
    endfunction

    // One full transaction from grant to the return to IDLE. lat = 0 means the
    // stub never answers; keep leaves every requester asserted afterwards.
    task automatic apply_stimulus(input logic [N-1:0] vld, input int lat, input bit stale, input bit keep);
        int         g;
        int         exp_lat;
        int         cyc;
        int         p;
        logic [OW-1:0] ma;
        logic [OW-1:0] mb;
        logic [PW-1:0] exp_prod;
        bit         stable;

        g        = pick(vld);
        ma       = a_op[g];
        mb       = b_op[g];
        p        = int'(ma) * int'(mb);
        exp_prod = (lat == 0) ? '0 : PW'(p % 128);
        exp_lat  = (lat == 0) ? TO + 2 : lat + 3;
        stub_lat   = lat;
        stale_done = stale;
        req_valid  = vld;
        #1;
        check_output("grant_ready", 32'(req_ready), 32'(1 << g));

        tick();
        cyc = 1;
        if (!keep) req_valid = '0;
        check_output("launch_st", 32'(mul_st), 32'd1);
        check_output("launch_mplier", 32'(mul_mplier), 32'(ma));
        check_output("launch_mcand", 32'(mul_mcand), 32'(mb));
        check_output("launch_busy", 32'(busy), 32'd1);

        stable = 1'b1;
        while (rsp_valid === '0 && cyc < exp_lat + 5) begin
            tick();
            cyc++;
            if (stale && cyc == 3) stale_done = 1'b0;
            if (rsp_valid === '0) begin
                if (mul_mplier !== ma || mul_mcand !== mb || mul_st !== 1'b0 || req_ready !== '0)
                    stable = 1'b0;
            end
        end
        check_output("wait_hold", 32'(stable), 32'd1);
        check_output("rsp_latency", 32'(cyc), 32'(exp_lat));
        check_output("rsp_owner", 32'(rsp_valid), 32'(1 << g));
        check_output("rsp_product", 32'(rsp_product), 32'(exp_prod));
        check_output("rsp_error", 32'(rsp_error), 32'(lat == 0));

        tick();
        check_output("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("idle_rsp_product", 32'(rsp_product), 32'd0);
        check_output("idle_busy", 32'(busy), 32'd0);
        ptr_m = (g + 1) % N;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            a_op[i] = OW'($urandom_range(0, 15));
            b_op[i] = OW'($urandom_range(0, 15));
        end
    endtask

    initial begin
        check_cnt  = 0;
        pass_cnt   = 0;
        ptr_m      = 0;
        stub_lat   = 4;
        stale_done = 1'b0;
        req_valid  = '0;
        rsp_valid_init();
        rst_n = 1'b0;
        #1;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_st", 32'(mul_st), 32'd0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_mplier", 32'(mul_mplier), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] contention: all requesters valid");
        for (int k = 0; k < 5; k++) begin
            randomize_ops();
            apply_stimulus(4'b1111, int'($urandom_range(1, 6)), 1'b0, 1'b1);
        end
        req_valid = '0;
        tick();

        $display("[TB] single op req0 F*F");
        a_op[0] = 4'hF;
        b_op[0] = 4'hF;
        apply_stimulus(4'b0001, 4, 1'b0, 1'b0);

        $display("[TB] timeout then normal op");
        randomize_ops();
        apply_stimulus(4'b0100, 0, 1'b0, 1'b0);
        randomize_ops();
        apply_stimulus(4'b1000, int'($urandom_range(1, 6)), 1'b0, 1'b0);

        $display("[TB] stale Done");
        randomize_ops();
        apply_stimulus(4'b0010, 3, 1'b1, 1'b0);

        $display("[TB] back-to-back req1");
        a_op[1] = 4'd8;
        b_op[1] = 4'd8;
        apply_stimulus(4'b0010, int'($urandom_range(1, 6)), 1'b0, 1'b0);
        a_op[1] = 4'd5;
        b_op[1] = 4'd3;
        apply_stimulus(4'b0010, int'($urandom_range(1, 6)), 1'b0, 1'b0);

        $display("[TB] reset mid-WAIT");
        randomize_ops();
        stub_lat  = 20;
        req_valid = 4'b0100;
        #1;
        check_output("pre_reset_ready", 32'(req_ready), 32'(1 << pick(4'b0100)));
        tick();
        req_valid = '0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("areset_st", 32'(mul_st), 32'd0);
        check_output("areset_ops", 32'({mul_mplier, mul_mcand}), 32'd0);
        check_output("areset_busy", 32'(busy), 32'd0);
        check_output("areset_rsp", 32'({rsp_valid, rsp_product, rsp_error}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        for (int k = 0; k < 4; k++) tick();
        check_output("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        randomize_ops();
        apply_stimulus(4'b1100, int'($urandom_range(1, 6)), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    task automatic rsp_valid_init();
        for (int i = 0; i < N; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
    endtask

endmodule
